// File: rtl/even_odd_gen_pkg.sv
// even_odd_gen_pkg: shared parity constants, state encoding and first-value helper
package even_odd_pkg;
  localparam logic EVEN = 1'b1;
  localparam logic ODD = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic first_value(input logic parity);
    return parity == EVEN ? 1'b0 : 1'b1;
  endfunction
endpackage

// File: rtl/even_odd_seq_ctr.sv
// even_odd_seq_ctr: number register stepping by 2 plus remaining-beat down-counter
module even_odd_seq_ctr
  import even_odd_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             parity,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] number,
  output logic             last
);
  logic [CNT_W-1:0] remaining;
  always_ff @(posedge clk) begin
    if (rst) begin
      number <= '0;
      remaining <= '0;
    end else if (load) begin
      number <= {{(WIDTH-1){1'b0}}, first_value(parity)};
      remaining <= count;
    end else if (step) begin
      number <= number + WIDTH'(2);
      remaining <= remaining - CNT_W'(1);
    end
  end
  assign last = remaining == CNT_W'(1);
endmodule

// File: rtl/even_odd_gen.sv
// even_odd_gen: emits COUNT numbers of a requested parity over valid/ready.
// Define EVEN_ODD_GEN_CHECK_EN to enable the sticky per-beat parity self-check.
module even_odd_gen
  import even_odd_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             parity_sel,
  input  logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic             parity_err
);
  state_t state;
  logic   par_q;
  logic   last;
  logic   beat;
  logic   load;
  assign beat = state == RUN && out_valid && out_ready;
  assign load = state == IDLE && start && count != '0;
  even_odd_seq_ctr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(beat),
    .parity(parity_sel),
    .count(count),
    .number(number),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      par_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          par_q <= parity_sel;
          state <= count != '0 ? RUN : DONE;
          out_valid <= count != '0;
          busy <= count != '0;
        end
        RUN: if (beat && last) begin
          state <= DONE;
          out_valid <= 1'b0;
          busy <= 1'b0;
        end
        DONE: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef EVEN_ODD_GEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else if (beat && (number[0] == par_q)) begin
      parity_err <= 1'b1;
      $display("even_odd_gen: parity error on value %0d", number);
    end
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_even_odd_gen.sv
// tb_even_odd_gen: randomized stimulus checked against an arithmetic sequence model
module tb_even_odd_gen;
  localparam int W = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst, start, parity_sel, out_ready;
  logic [CW-1:0] count;
  logic out_valid, busy, done, parity_err;
  logic [W-1:0] number;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  even_odd_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .parity_sel(parity_sel),
    .count(count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .number(number),
    .busy(busy),
    .done(done),
    .parity_err(parity_err)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int expect_num(input logic par, input int idx);
    return ((par ? 0 : 1) + 2 * idx) % (1 << W);
  endfunction
  // mode 0: ready held high, 1: ready toggles 1,0,1..., 2: random ready
  task automatic run_seq(input logic par, input int cnt, input int mode, input bit noise);
    int idx = 0;
    int cyc = 0;
    @(negedge clk);
    start = 1'b1;
    parity_sel = par;
    count = CW'(cnt);
    @(negedge clk);
    start = 1'b0;
    while (idx < cnt && cyc < 200) begin
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("number", number, expect_num(par, idx));
      check("done_run", done, 0);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~cyc[0] : 1'($urandom);
      start = noise ? 1'($urandom) : 1'b0;
      parity_sel = 1'($urandom);
      count = CW'($urandom);
      cyc++;
      @(negedge clk);
      if (out_ready) idx++;
    end
    start = 1'b0;
    out_ready = 1'($urandom);
    check("beats", idx, cnt);
    check("valid_end", out_valid, 0);
    check("busy_end", busy, 0);
    check("done_early", done, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("valid_idle", out_valid, 0);
    @(negedge clk);
    check("done_clear", done, 0);
    check("parity_err", parity_err, 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    parity_sel = 1'b0;
    count = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_number", number, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_perr", parity_err, 0);
    rst = 1'b0;
    run_seq(1'b1, 4, 0, 1'b0);
    run_seq(1'b0, 3, 1, 1'b0);
    run_seq(1'b1, 10, 0, 1'b1);
    run_seq(1'b0, 10, 2, 1'b1);
    run_seq(1'b1, 0, 0, 1'b0);
    run_seq(1'b0, 15, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    parity_sel = 1'b0;
    count = 4'd5;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_num", number, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_number", number, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    check("mid_rst_nodone", done, 0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    count = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_valid", out_valid, 0);
    check("rst_start_busy", busy, 0);
    run_seq(1'b0, 5, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      run_seq(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
